// File: rtl/pdh_pkg.sv
// Shared types and widths for the PDH
// sample capture path.
package pdh_pkg;

  localparam int ADC_DW_DEF = 14;
  localparam int HALF_W     = 16;
  localparam int PAIR_W     = 32;
  localparam int WORD_W     = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock first-word-fall-through
// buffer with full/empty flags.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push;
  logic             pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // a read frees a slot in the same cycle
  assign push = wr_en && (!full || rd_en);
  assign pop  = rd_en && !empty;

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // read/write pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sample_packer.sv
// Decimates ADC A/B pairs and packs two
// pairs per 64-bit word into a buffer.
module sample_packer
  import pdh_pkg::*;
#(
  parameter int ADC_DATA_WIDTH = ADC_DW_DEF,
  parameter int DECIM_WIDTH    = 22,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable_i,
  input  logic [DECIM_WIDTH-1:0]    decimation_code_i,
  input  logic [ADC_DATA_WIDTH-1:0] adc_a_i,
  input  logic [ADC_DATA_WIDTH-1:0] adc_b_i,
  output logic [WORD_W-1:0]         data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      overflow_o,
  output logic [31:0]               word_count_o,
  output logic                      busy_o
);

  state_t state;
  state_t state_nx;

  logic                   en_q;
  logic                   rise;
  logic [DECIM_WIDTH-1:0] code_q;
  logic [DECIM_WIDTH-1:0] dec_cnt;
  logic                   half_q;
  logic [PAIR_W-1:0]      first_q;
  logic [PAIR_W-1:0]      pair;
  logic [HALF_W-1:0]      ext_a;
  logic [HALF_W-1:0]      ext_b;

  logic start;
  logic stop;
  logic sample_en;

  logic              wr_en;
  logic [WORD_W-1:0] wr_data;
  logic              rd_en;
  logic              full;
  logic              empty;

  assign rise  = enable_i && !en_q;
  assign ext_a = HALF_W'($signed(adc_a_i));
  assign ext_b = HALF_W'($signed(adc_b_i));
  assign pair  = {ext_b, ext_a};

  assign wr_en   = sample_en && half_q;
  assign wr_data = {pair, first_q};
  assign valid_o = !empty;
  assign rd_en   = valid_o && ready_i;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (rise)      state_nx = ST_RUN;
      ST_RUN:  if (!enable_i) state_nx = ST_IDLE;
      default:                state_nx = ST_IDLE;
    endcase
  end

  // FSM-derived controls
  always_comb begin
    busy_o    = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    sample_en = 1'b0;
    unique case (state)
      ST_IDLE: start = rise;
      ST_RUN: begin
        busy_o    = 1'b1;
        stop      = !enable_i;
        sample_en = enable_i && (dec_cnt == '0);
      end
      default: ;
    endcase
  end

  // enable edge detect; reset high so a held
  // enable cannot start capture after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_q <= 1'b1;
    else        en_q <= enable_i;
  end

  // decimation counter and half-word staging
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q  <= '0;
      dec_cnt <= '0;
      half_q  <= 1'b0;
      first_q <= '0;
    end else if (start) begin
      code_q  <= decimation_code_i;
      dec_cnt <= '0;
      half_q  <= 1'b0;
    end else if (stop) begin
      dec_cnt <= '0;
      half_q  <= 1'b0;
    end else if (state == ST_RUN) begin
      if (dec_cnt == code_q) dec_cnt <= '0;
      else                   dec_cnt <= dec_cnt + 1'b1;
      if (sample_en) begin
        half_q <= !half_q;
        if (!half_q) first_q <= pair;
      end
    end
  end

  // sticky drop flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         overflow_o <= 1'b0;
    else if (start)                     overflow_o <= 1'b0;
    else if (wr_en && full && !rd_en)   overflow_o <= 1'b1;
  end

  // accepted word counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     word_count_o <= '0;
    else if (start) word_count_o <= '0;
    else if (rd_en) word_count_o <= word_count_o + 1'b1;
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (data_o),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: doc/sample_packer.md
SAMPLE_PACKER -- requirements
Module: sample_packer

Interface
REQ-001 Parameter ADC_DATA_WIDTH, default 14: width of each ADC channel sample.
REQ-002 Parameter DECIM_WIDTH, default 22: width of the decimation code.
REQ-003 Parameter FIFO_DEPTH, default 4: output buffer depth in 64-bit words; SHALL be a power of two, at least 2.
REQ-004 clk  input  1: ADC-domain clock; the only clock in the block.
REQ-005 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-006 enable_i  input  1: capture enable from the core.
REQ-007 decimation_code_i  input  DECIM_WIDTH: one pair is kept every (code+1) clocks.
REQ-008 adc_a_i  input  ADC_DATA_WIDTH: signed channel-A sample, new value every clk.
REQ-009 adc_b_i  input  ADC_DATA_WIDTH: signed channel-B sample, new value every clk.
REQ-010 data_o  output  64: packed word presented to the downstream buffer.
REQ-011 valid_o  output  1: data_o holds a valid word.
REQ-012 ready_i  input  1: downstream accepts data_o in this cycle.
REQ-013 overflow_o  output  1: sticky flag; a completed word was dropped because the buffer was full.
REQ-014 word_count_o  output  32: number of words accepted by downstream since the last capture start.
REQ-015 busy_o  output  1: high in state RUN.

Function
REQ-016 The FSM SHALL have two states, IDLE and RUN; IDLE->RUN on a rising edge of enable_i, and RUN->IDLE in the first cycle enable_i is low.
REQ-017 On IDLE->RUN, the block SHALL latch decimation_code_i, clear the decimation counter, the half-word flag, overflow_o, and word_count_o; it SHALL NOT flush the buffer.
REQ-018 In RUN, a pair SHALL be sampled in the entry cycle and then every (latched code+1) cycles; code 0 samples every cycle; changes on decimation_code_i during RUN SHALL be ignored.
REQ-019 Pair packing: pair = {sign-extend(b) to 16, sign-extend(a) to 16}; word = {second pair in [63:32], first pair in [31:0]}.
REQ-020 A completed word SHALL be written to the buffer on the edge that samples the second pair; valid_o SHALL assert on the next cycle if the buffer was empty (latency 1 cycle).
REQ-021 Handshake: a word transfers when valid_o and ready_i are both high; data_o SHALL be stable while valid_o is high and ready_i is low.
REQ-022 A simultaneous write and read at full SHALL succeed; a write at full without a read SHALL drop the new word and set overflow_o.
REQ-023 word_count_o SHALL increment by 1 per transfer and wrap from 0xFFFFFFFF to 0.
REQ-024 On RUN->IDLE, a pending half word SHALL be discarded; buffered words SHALL keep draining in IDLE.
REQ-025 The decimation counter SHALL wrap at the latched code without skipping or repeating a sample, including code = 2^DECIM_WIDTH-1.

Reset
REQ-026 While rst_n is low: state IDLE; buffer empty; valid_o=0, data_o=0, overflow_o=0, word_count_o=0, busy_o=0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered and partial data immediately.
REQ-028 After rst_n deasserts, enable_i already high SHALL NOT start capture; a new rising edge is required.

Structure
REQ-029 The default ADC width, the pair/word widths, and the FSM state enum SHALL live in the shared pdh_pkg package.
REQ-030 The buffer SHALL be a sub-module sample_fifo (synchronous, single clock, first-word-fall-through, full/empty outputs).

Verification
REQ-031 Scenario 1: code=0; a=1, b=-1 constant; enable rises; ready_i=1 -> first valid_o two cycles after entry, data_o=0xFFFF0001_FFFF0001.
REQ-032 Scenario 2: code=3; a ramps +1 per clk from 0 -> a fields are 0,4 / 8,12; words are spaced 8 cycles apart.
REQ-033 Scenario 3: ready_i=0; code=0; FIFO_DEPTH=4 -> 4 words buffered; the 5th word sets overflow_o; data_o holds word 0.
REQ-034 Scenario 4: enable falls after 3 pairs -> exactly 1 word emitted; the third pair is never output; word_count_o=1.
REQ-035 Scenario 5: rst_n pulsed low with 2 words buffered -> valid_o=0 at once; after release with enable_i held high, no capture starts.
REQ-036 Scenario 6: ready_i toggles randomly, 1000 words -> data_o stable while stalled; word_count_o=1000; overflow_o=0 when code>=1.
